// File: rtl/i2c_pkg.sv
// Shared types for the I2C command sequencer: the queued command record,
// the sequencer FSM states and the op encodings presented to the I2C top.
package i2c_pkg;

    localparam logic I2C_OP_WRITE = 1'b0;
    localparam logic I2C_OP_READ  = 1'b1;

    typedef struct packed {
        logic       op;
        logic [6:0] addr;
        logic [7:0] data;
    } i2c_cmd_t;

    // ST_HOLD is only reachable when the retry feature is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_HOLD  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO. DEPTH must be a power of two so that the
// read/write pointers wrap naturally. Pushes while full and pops while
// empty are ignored. Level output is the registered occupancy count.
module i2c_cmd_fifo
    import i2c_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  i2c_cmd_t      i_wdata,
    input  logic          i_pop,
    output i2c_cmd_t      o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level
);

    i2c_cmd_t      r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == LW'(DEPTH));
    assign o_empty = (r_count == {LW{1'b0}});
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_count;

    // Storage array: written at the write pointer on an accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers advance modulo DEPTH through natural wrap of AW bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy count; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= {LW{1'b0}};
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Command-queue front end for the I2C top level. Host commands are
// buffered in a FIFO and issued one at a time with a one-cycle newd
// pulse; the block waits for done and returns one response per command.
// Optional feature: define I2C_SEQ_RETRY_EN to reissue NACKed
// transactions up to MAX_RETRY times before reporting rsp_err.
module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int  DEPTH     = 8,
    parameter int  MAX_RETRY = 3,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [6:0]    cmd_addr,
    input  logic [7:0]    cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [7:0]    rsp_data,
    output logic          rsp_err,
    output logic          i2c_newd,
    output logic          i2c_op,
    output logic [6:0]    i2c_addr,
    output logic [7:0]    i2c_din,
    input  logic [7:0]    i2c_dout,
    input  logic          i2c_busy,
    input  logic          i2c_ack_err,
    input  logic          i2c_done,
    output logic [LW-1:0] queue_level,
    output logic          idle
);

    seq_state_t    r_state;
    seq_state_t    w_next_state;

    i2c_cmd_t      w_wdata;
    i2c_cmd_t      w_head;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_level;

    logic          r_newd;
    logic          r_op;
    logic [6:0]    r_addr;
    logic [7:0]    r_din;
    logic          r_rsp_valid;
    logic [7:0]    r_rsp_data;
    logic          r_rsp_err;

    logic          w_newd;
    logic          w_op;
    logic [6:0]    w_addr;
    logic [7:0]    w_din;
    logic          w_rsp_valid;
    logic [7:0]    w_rsp_data;
    logic          w_rsp_err;

`ifdef I2C_SEQ_RETRY_EN
    localparam int            CW     = $clog2(MAX_RETRY + 1);
    localparam logic [CW-1:0] LP_MAX = CW'(MAX_RETRY);
    logic [CW-1:0] r_retry_cnt;
    logic [CW-1:0] w_retry_cnt;
`endif

    assign w_wdata.op   = cmd_op;
    assign w_wdata.addr = cmd_addr;
    assign w_wdata.data = cmd_data;
    assign cmd_ready    = !w_full;
    assign w_push       = cmd_valid && cmd_ready;

    i2c_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign queue_level = w_level;
    assign idle        = w_empty && (r_state == ST_IDLE) && !r_rsp_valid;
    assign i2c_newd    = r_newd;
    assign i2c_op      = r_op;
    assign i2c_addr    = r_addr;
    assign i2c_din     = r_din;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and next values for every registered output.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_newd       = 1'b0;
        w_op         = r_op;
        w_addr       = r_addr;
        w_din        = r_din;
        w_rsp_valid  = r_rsp_valid;
        w_rsp_data   = r_rsp_data;
        w_rsp_err    = r_rsp_err;
`ifdef I2C_SEQ_RETRY_EN
        w_retry_cnt  = r_retry_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                // The bus must be fully quiet (no busy, no trailing done).
                if (!w_empty && !i2c_busy && !i2c_done) begin
                    w_pop        = 1'b1;
                    w_op         = w_head.op;
                    w_addr       = w_head.addr;
                    w_din        = w_head.data;
                    w_newd       = 1'b1;
                    w_next_state = ST_ISSUE;
`ifdef I2C_SEQ_RETRY_EN
                    w_retry_cnt  = {CW{1'b0}};
`endif
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (i2c_done) begin
                    if (!i2c_ack_err) begin
                        w_next_state = ST_RESP;
                        w_rsp_valid  = 1'b1;
                        w_rsp_err    = 1'b0;
                        w_rsp_data   = (r_op == I2C_OP_READ) ? i2c_dout : 8'h00;
                    end else begin
`ifdef I2C_SEQ_RETRY_EN
                        if (r_retry_cnt < LP_MAX) begin
                            w_retry_cnt  = r_retry_cnt + CW'(1);
                            w_next_state = ST_HOLD;
                        end else begin
                            w_next_state = ST_RESP;
                            w_rsp_valid  = 1'b1;
                            w_rsp_err    = 1'b1;
                            w_rsp_data   = 8'h00;
                        end
`else
                        w_next_state = ST_RESP;
                        w_rsp_valid  = 1'b1;
                        w_rsp_err    = 1'b1;
                        w_rsp_data   = 8'h00;
`endif
                    end
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                    w_rsp_valid  = 1'b0;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            ST_HOLD: begin
`ifdef I2C_SEQ_RETRY_EN
                // Reissue the latched command without touching the FIFO.
                if (!i2c_busy && !i2c_done) begin
                    w_newd       = 1'b1;
                    w_next_state = ST_ISSUE;
                end else begin
                    w_next_state = ST_HOLD;
                end
`else
                w_next_state = ST_IDLE;
`endif
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Registered I2C-side and response-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_newd      <= 1'b0;
            r_op        <= 1'b0;
            r_addr      <= 7'h00;
            r_din       <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_rsp_err   <= 1'b0;
        end else begin
            r_newd      <= w_newd;
            r_op        <= w_op;
            r_addr      <= w_addr;
            r_din       <= w_din;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_rsp_err   <= w_rsp_err;
        end
    end

`ifdef I2C_SEQ_RETRY_EN
    // Retry counter: cleared on every pop, bumped on each NACKed attempt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retry_cnt <= {CW{1'b0}};
        end else begin
            r_retry_cnt <= w_retry_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer. A transaction-level model
// (queue of pushed commands, in-flight flag, expected response) plus a
// simple I2C-top responder run in one negedge process; directed tests
// pin the model with literal expectations, then a random phase follows.
module tb_i2c_cmd_sequencer;
    import i2c_pkg::*;

    localparam int DEPTH     = 8;
    localparam int MAX_RETRY = 3;
    localparam int LW        = $clog2(DEPTH) + 1;
`ifdef I2C_SEQ_RETRY_EN
    localparam bit RETRY_ON = 1'b1;
`else
    localparam bit RETRY_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_op;
    logic [6:0]    cmd_addr;
    logic [7:0]    cmd_data;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [7:0]    rsp_data;
    logic          i2c_newd, i2c_op;
    logic [6:0]    i2c_addr;
    logic [7:0]    i2c_din, i2c_dout;
    logic          i2c_busy, i2c_ack_err, i2c_done;
    logic [LW-1:0] queue_level;
    logic          idle;

    always #5 clk = ~clk;

    i2c_cmd_sequencer #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .i2c_newd(i2c_newd), .i2c_op(i2c_op), .i2c_addr(i2c_addr), .i2c_din(i2c_din),
        .i2c_dout(i2c_dout), .i2c_busy(i2c_busy), .i2c_ack_err(i2c_ack_err), .i2c_done(i2c_done),
        .queue_level(queue_level), .idle(idle)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state
    i2c_cmd_t exp_q[$];
    i2c_cmd_t cur;
    int       lvl = 0, attempts = 0;
    bit       inflight = 0, retry_pend = 0, exp_rv = 0, exp_re = 0, prev_newd = 0;
    bit [7:0] exp_rd = 8'h00;
    int       cyc = 0, n_newd = 0, n_rsp = 0, push_cyc = 0, newd_cyc = 0;
    bit [7:0] last_rsp_data, last_din;
    bit       last_rsp_err;
    bit [6:0] last_addr;
    // Responder state and configuration
    bit       s_busy = 0, hold_busy = 0;
    int       s_cnt = 0;
    bit       s_err = 0;
    bit [7:0] s_dout = 8'h00;
    int       cfg_lat_min = 2, cfg_lat_max = 4, cfg_err_pct = 0;
    bit       cfg_force_err = 0, cfg_fix_dout = 0;
    bit [7:0] cfg_dout = 8'h00;

    assign i2c_busy = s_busy | hold_busy;

    // Model, per-cycle compare and I2C-top responder, all at negedge.
    initial begin
        i2c_done = 1'b0; i2c_ack_err = 1'b0; i2c_dout = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete(); lvl = 0; inflight = 0; retry_pend = 0; exp_rv = 0;
                attempts = 0; prev_newd = 0; s_busy = 0; s_cnt = 0;
                i2c_done = 1'b0; i2c_ack_err = 1'b0; i2c_dout = 8'h00;
            end else begin
                if (i2c_newd) begin
                    chk("newd_one_cycle", prev_newd, 1'b0);
                    if (!inflight) begin
                        chk("newd_has_cmd", exp_q.size() > 0, 1'b1);
                        if (exp_q.size() > 0) begin
                            cur = exp_q.pop_front();
                            lvl--;
                        end
                        inflight = 1; attempts = 0;
                    end else begin
                        chk("newd_retry_allowed", retry_pend, 1'b1);
                    end
                    retry_pend = 0; attempts++; n_newd++; newd_cyc = cyc;
                    last_addr = i2c_addr; last_din = i2c_din;
                    chk("i2c_op", i2c_op, cur.op);
                    chk("i2c_addr", i2c_addr, cur.addr);
                    if (cur.op == I2C_OP_WRITE) chk("i2c_din", i2c_din, cur.data);
                end
                prev_newd = i2c_newd;
                chk("queue_level", queue_level, lvl);
                chk("cmd_ready", cmd_ready, lvl < DEPTH);
                chk("idle", idle, (lvl == 0) && !inflight);
                chk("rsp_valid", rsp_valid, exp_rv);
                if (exp_rv) begin
                    chk("rsp_data", rsp_data, exp_rd);
                    chk("rsp_err", rsp_err, exp_re);
                end
                if (rsp_valid && rsp_ready && exp_rv) begin
                    exp_rv = 0; inflight = 0; n_rsp++;
                    last_rsp_data = rsp_data; last_rsp_err = rsp_err;
                end
                if (cmd_valid && cmd_ready) begin
                    i2c_cmd_t c;
                    c.op = cmd_op; c.addr = cmd_addr; c.data = cmd_data;
                    exp_q.push_back(c); lvl++; push_cyc = cyc;
                end
                // Responder: done lasts one cycle; busy spans the latency.
                if (i2c_done) begin
                    i2c_done = 1'b0; i2c_ack_err = 1'b0; i2c_dout = 8'h00;
                end
                if (i2c_newd) begin
                    s_busy = 1; s_cnt = $urandom_range(cfg_lat_max, cfg_lat_min);
                    s_err  = cfg_force_err || ($urandom_range(99, 0) < cfg_err_pct);
                    s_dout = cfg_fix_dout ? cfg_dout : 8'($urandom);
                end else if (s_busy) begin
                    s_cnt--;
                    if (s_cnt == 0) begin
                        s_busy = 0; i2c_done = 1'b1; i2c_ack_err = s_err; i2c_dout = s_dout;
                        if (!s_err) begin
                            exp_rv = 1; exp_re = 0;
                            exp_rd = (cur.op == I2C_OP_READ) ? s_dout : 8'h00;
                        end else if (RETRY_ON && attempts <= MAX_RETRY) begin
                            retry_pend = 1;
                        end else begin
                            exp_rv = 1; exp_re = 1; exp_rd = 8'h00;
                        end
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, "_idle"}, idle, 1'b1);
        chk({tag, "_queue_level"}, queue_level, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_rsp_data"}, rsp_data, 8'h00);
        chk({tag, "_rsp_err"}, rsp_err, 1'b0);
        chk({tag, "_newd"}, i2c_newd, 1'b0);
        chk({tag, "_op"}, i2c_op, 1'b0);
        chk({tag, "_addr"}, i2c_addr, 7'h00);
        chk({tag, "_din"}, i2c_din, 8'h00);
    endtask

    // Called at posedge+1; returns at posedge+1 after the push edge.
    task automatic push(input logic op, input logic [6:0] a, input logic [7:0] d);
        int t;
        t = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        @(negedge clk);
        while (!cmd_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) chk("push_timeout", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input int hold);
        int t;
        t = 0;
        while (!rsp_valid && t < 600) begin
            @(posedge clk); #1;
            t++;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", rsp_valid, 1'b1);
        end else begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("rsp_held_valid", rsp_valid, 1'b1);
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic wait_drained();
        int t;
        t = 0;
        while ((lvl != 0 || inflight) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain", (lvl == 0) && !inflight, 1'b1);
    endtask

    // Directed tests, then randomized traffic.
    initial begin
        int base, base_rsp;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = 7'h00; cmd_data = 8'h00;
        rsp_ready = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Single write, done after 40 cycles
        cfg_lat_min = 40; cfg_lat_max = 40;
        base = n_newd;
        push(I2C_OP_WRITE, 7'h50, 8'hA5);
        get_rsp(0);
        chk("t1_pulses", n_newd - base, 1);
        chk("t1_issue_latency", newd_cyc - push_cyc, 2);
        chk("t1_addr", last_addr, 7'h50);
        chk("t1_din", last_din, 8'hA5);
        chk("t1_rsp_data", last_rsp_data, 8'h00);
        chk("t1_rsp_err", last_rsp_err, 1'b0);

        // Read with 10 cycles of back-pressure
        cfg_lat_min = 6; cfg_lat_max = 6; cfg_fix_dout = 1; cfg_dout = 8'h3C;
        base = n_newd;
        push(I2C_OP_READ, 7'h50, 8'h00);
        get_rsp(10);
        chk("t2_pulses", n_newd - base, 1);
        chk("t2_rsp_data", last_rsp_data, 8'h3C);
        chk("t2_rsp_err", last_rsp_err, 1'b0);
        cfg_fix_dout = 0;

        // Full queue while the bus is held busy
        cfg_lat_min = 3; cfg_lat_max = 5; hold_busy = 1;
        base_rsp = n_rsp;
        for (int i = 0; i < DEPTH; i++) begin
            push(1'(i), 7'(8'h10 + i), 8'(i * 17));
        end
        chk("t3_level_full", queue_level, 8);
        chk("t3_ready_full", cmd_ready, 1'b0);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 7'h7F; cmd_data = 8'hEE;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("t3_level_after_refused", queue_level, 8);
        hold_busy = 0;
        for (int i = 0; i < DEPTH; i++) get_rsp(0);
        chk("t3_rsp_count", n_rsp - base_rsp, DEPTH);

        // Every attempt NACKed
        cfg_lat_min = 2; cfg_lat_max = 4; cfg_force_err = 1;
        base = n_newd;
        push(I2C_OP_WRITE, 7'h22, 8'h5A);
        get_rsp(0);
        chk("t4_pulses", n_newd - base, RETRY_ON ? (1 + MAX_RETRY) : 1);
        chk("t4_rsp_err", last_rsp_err, 1'b1);
        chk("t4_rsp_data", last_rsp_data, 8'h00);
        cfg_force_err = 0;

        // Reset in the middle of WAIT with three commands queued
        cfg_lat_min = 60; cfg_lat_max = 60;
        for (int i = 0; i < 4; i++) push(1'b0, 7'(8'h40 + i), 8'(i));
        repeat (6) @(posedge clk);
        #1;
        chk("t5_level_before_rst", queue_level, 3);
        base_rsp = n_rsp;
        rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_no_rsp", n_rsp - base_rsp, 0);
        chk("t5_idle_after", idle, 1'b1);
        cfg_lat_min = 3; cfg_lat_max = 3;
        base = n_newd;
        push(I2C_OP_WRITE, 7'h33, 8'h77);
        get_rsp(0);
        chk("t5_new_pulses", n_newd - base, 1);
        chk("t5_new_addr", last_addr, 7'h33);

        // Randomized traffic
        cfg_lat_min = 1; cfg_lat_max = 6; cfg_err_pct = 25;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'($urandom_range(1, 0));
            cmd_op    = 1'($urandom_range(1, 0));
            cmd_addr  = 7'($urandom);
            cmd_data  = 8'($urandom);
            rsp_ready = ($urandom_range(2, 0) != 0);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        wait_drained();
        @(posedge clk); #1;
        chk("final_idle", idle, 1'b1);
        rsp_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_sequencer.md
# i2c_cmd_sequencer

Command-queue front end that sits directly upstream of the I2C top level, driving its `newd`/`op`/`addr`/`din` inputs and consuming its `dout`/`busy`/`ack_err`/`done` outputs. It buffers host transactions in a FIFO and issues them one at a time. It waits for each transaction to complete and returns one response per command through a valid/ready channel. With the retry feature compiled in, NACKed transactions are reissued automatically.

## Interface
- `DEPTH`, 8: command FIFO depth; power of two, ≥2.
- `MAX_RETRY`, 3: maximum reissues after `ack_err`; range 1–15. Used only when retry is compiled in.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  FIFO can accept a command (`!full`).
- `cmd_op`  in  1  0 = write, 1 = read.
- `cmd_addr`  in  7  7-bit slave address.
- `cmd_data`  in  8  write byte; ignored for reads.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  host accepts response.
- `rsp_data`  out  8  read byte; 0 for writes.
- `rsp_err`  out  1  final attempt ended with `ack_err`.
- `i2c_newd`  out  1  one-cycle start pulse to the I2C top.
- `i2c_op`  out  1  op for the current transaction.
- `i2c_addr`  out  7  address for the current transaction.
- `i2c_din`  out  8  write data for the current transaction.
- `i2c_dout`  in  8  read data from the I2C top.
- `i2c_busy`  in  1  I2C top busy.
- `i2c_ack_err`  in  1  I2C top acknowledge error.
- `i2c_done`  in  1  I2C top transaction complete.
- `queue_level`  out  $clog2(DEPTH)+1  number of commands currently queued.
- `idle`  out  1  FIFO empty, FSM in IDLE, and no response pending.

## Operation
- **FIFO**
  - A push occurs on `cmd_valid && cmd_ready`.
  - A pop occurs only on the IDLE→ISSUE transition.
  - Push and pop in the same cycle leave `queue_level` unchanged.
  - When the FIFO is full, `cmd_ready` is 0 even if a pop happens that cycle.
  - Read and write pointers wrap modulo DEPTH.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE→ISSUE** when all of the following hold:
  - FIFO is not empty.
  - `i2c_busy == 0` and `i2c_done == 0`.
  - The popped entry is latched into `i2c_op`/`i2c_addr`/`i2c_din`.
- **ISSUE→WAIT** after exactly one cycle, during which `i2c_newd` is 1.
- **WAIT** ends on the first cycle with `i2c_done == 1`. In that cycle the block samples `i2c_ack_err` and `i2c_dout`.
  - No error → RESP. `rsp_data` = `i2c_dout` for reads, 0 for writes; `rsp_err` = 0.
  - Error → retry or RESP with `rsp_err` = 1 (see Configuration).
- **RESP:** `rsp_valid` is held with data stable until `rsp_ready`. Then the FSM returns to IDLE.
  - While RESP is held, the FIFO keeps accepting commands but nothing is issued.
- `i2c_op`/`i2c_addr`/`i2c_din` stay stable from ISSUE until the next IDLE→ISSUE.
- **Mid-operation reset:**
  - FIFO is flushed and the FSM goes to IDLE.
  - The in-flight transaction is abandoned with no response.
  - All outputs return to their reset values.

## Timing
- **Reset values:**
  - `cmd_ready` = 1, `idle` = 1.
  - `queue_level`, `rsp_valid`, `rsp_data`, `rsp_err` = 0.
  - `i2c_newd`, `i2c_op`, `i2c_addr`, `i2c_din` = 0.
- All outputs are registered except `cmd_ready` and `idle`, which decode registered state.
- **Issue latency:** a push into an empty FIFO with the bus free gives `i2c_newd` high 2 cycles after the push edge (push, IDLE→ISSUE, pulse).
- **Response latency:** `rsp_valid` rises 1 cycle after the `i2c_done` sample.
- **Back-to-back:** minimum 1 IDLE cycle between `rsp_ready` acceptance and the next ISSUE.

## Configuration
- **Macro:** `I2C_SEQ_RETRY_EN`.
- **Defined:**
  - In WAIT, `i2c_done && i2c_ack_err` with retry count < MAX_RETRY → increment the count and go to IDLE-hold.
  - In IDLE-hold the same command is reissued without popping; the ISSUE entry condition still applies.
  - After MAX_RETRY failed reissues → RESP with `rsp_err` = 1.
  - The retry count clears on every pop.
  - Counter width is $clog2(MAX_RETRY+1).
- **Undefined:**
  - The first `ack_err` goes straight to RESP with `rsp_err` = 1.
  - No retry counter is built, and `MAX_RETRY` is ignored.

## Structure
- **Shared package `i2c_pkg`:**
  - Command struct `{op, addr[6:0], data[7:0]}`.
  - FSM state enum.
  - `I2C_OP_WRITE`/`I2C_OP_READ` constants.
- **Sub-module `i2c_cmd_fifo`:**
  - Synchronous FIFO with parameter DEPTH.
  - Ports: push/pop, full/empty, level.
  - Asynchronous active-high reset.

## Test plan
- **Single write:** push write addr 0x50 data 0xA5, bench model returns `done` after 40 cycles with no error → exactly one `i2c_newd` pulse carrying 0x50/0xA5; response `rsp_data` = 0x00, `rsp_err` = 0.
- **Read with back-pressure:** push read addr 0x50, model returns `dout` = 0x3C, `rsp_ready` held low 10 cycles → `rsp_valid` stays high with data 0x3C stable; no second `i2c_newd`.
- **Full queue:** push DEPTH commands while the model holds `busy` → `queue_level` = 8, `cmd_ready` = 0; the 9th push is refused. Responses come out in push order.
- **Retry:** macro on, model NACKs every attempt → 1 + MAX_RETRY = 4 `i2c_newd` pulses, then `rsp_err` = 1.
  - Repeat with the macro off → 1 pulse, then `rsp_err` = 1.
- **Reset mid-WAIT:** assert `rst` mid-WAIT with 3 commands queued → all outputs return to reset values asynchronously; no response emitted.
  - After release, a new push is issued normally.
